reg_pipe_tap: RTL and testbench

Parametrised multi-stage input pipeline for the DSP48A1 datapath, generalising the single optional operand register into a chain of up to DEPTH registers with a runtime-selectable output tap. Each stage carries a valid bit alongside its data, so downstream logic knows when the selected tap holds real samples. Supports clock enable, flush and a saturating fill counter. Sits in front of the pre-adder/multiplier operand paths, where it replaces fixed 0/1/2-stage register muxes.

---
 rtl/reg_pipe_tap_if.sv | 26 ++
 rtl/reg_pipe_tap.sv | 61 ++++++
 tb/tb_reg_pipe_tap.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/reg_pipe_tap_if.sv
// Bus for reg_pipe_tap: control, sample input, tap select and tapped outputs.
interface reg_pipe_tap_if #(
  parameter int unsigned SIZE  = 18,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned TW = $clog2(DEPTH + 1);

  logic            CE;
  logic            FLUSH;
  logic [SIZE-1:0] D;
  logic            D_VLD;
  logic [TW-1:0]   TAP;
  logic [SIZE-1:0] OUT;
  logic            OUT_VLD;
  logic [TW-1:0]   FILL;

  modport master (
    output CE, FLUSH, D, D_VLD, TAP,
    input  OUT, OUT_VLD, FILL
  );

  modport slave (
    input  CE, FLUSH, D, D_VLD, TAP,
    output OUT, OUT_VLD, FILL
  );
endinterface

// File: rtl/reg_pipe_tap.sv
// Multi-stage operand pipeline with per-stage valid bits, runtime tap select,
// flush and a saturating count of valid samples accepted.
module reg_pipe_tap #(
  parameter int unsigned           SIZE   = 18,
  parameter int unsigned           DEPTH  = 4,
  parameter logic [SIZE-1:0]       RSTVAL = '0
) (
  input  logic          CLK,
  input  logic          RST,
  reg_pipe_tap_if.slave bus
);
  localparam int unsigned TW = $clog2(DEPTH + 1);

  logic [SIZE-1:0] r_data [1:DEPTH];
  logic            r_vld  [1:DEPTH];
  logic [TW-1:0]   r_fill;

  logic [TW-1:0]   w_tap;
  logic [SIZE-1:0] w_out;
  logic            w_out_vld;

  // Chain update: reset and flush clear everything and win over the shift.
  always_ff @(posedge CLK) begin
    if (RST || bus.FLUSH) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        r_data[k] <= RSTVAL;
        r_vld[k]  <= 1'b0;
      end
      r_fill <= '0;
    end else if (bus.CE) begin
      r_data[1] <= bus.D;
      r_vld[1]  <= bus.D_VLD;
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        r_data[k] <= r_data[k-1];
        r_vld[k]  <= r_vld[k-1];
      end
      if (bus.D_VLD && (r_fill < TW'(DEPTH))) begin
        r_fill <= r_fill + TW'(1);
      end
    end
  end

  // Taps beyond the last stage read the last stage.
  assign w_tap = (bus.TAP > TW'(DEPTH)) ? TW'(DEPTH) : bus.TAP;

  // Tap mux; tap 0 is a combinational bypass of the input.
  always_comb begin
    w_out     = bus.D;
    w_out_vld = bus.D_VLD;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (w_tap == TW'(k)) begin
        w_out     = r_data[k];
        w_out_vld = r_vld[k];
      end
    end
  end

  assign bus.OUT     = w_out;
  assign bus.OUT_VLD = w_out_vld;
  assign bus.FILL    = r_fill;
endmodule

// File: tb/tb_reg_pipe_tap.sv
// Self-checking bench for reg_pipe_tap: directed scenarios plus random traffic
// compared against a queue-based model of the last DEPTH accepted samples.
`timescale 1ns/1ps
module tb_reg_pipe_tap;
  localparam int unsigned SIZE  = 18;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = $clog2(DEPTH + 1);

  logic CLK = 1'b0;
  logic RST;

  reg_pipe_tap_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

  reg_pipe_tap #(.SIZE(SIZE), .DEPTH(DEPTH), .RSTVAL('0)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #10 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model: element 0 of each queue is the most recently shifted-in sample.
  logic [SIZE-1:0] q_d [$];
  bit              q_v [$];
  int              m_fill = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_tap(input int t);
    return (t > int'(DEPTH)) ? int'(DEPTH) : t;
  endfunction

  // Present inputs for one cycle, check outputs against the model, take the edge.
  task automatic step(input bit rst, input bit flush, input bit ce,
                      input logic [SIZE-1:0] d, input bit dv, input int tap);
    int t;
    @(negedge CLK);
    RST       = rst;
    bus.FLUSH = flush;
    bus.CE    = ce;
    bus.D     = d;
    bus.D_VLD = dv;
    bus.TAP   = TW'(tap);
    #1;
    if (chk_en) begin
      t = clamp_tap(tap);
      chk("out",  32'(bus.OUT),     (t == 0) ? 32'(d)  : 32'(q_d[t-1]));
      chk("vld",  32'(bus.OUT_VLD), (t == 0) ? 32'(dv) : 32'(q_v[t-1]));
      chk("fill", 32'(bus.FILL),    32'(m_fill));
    end
    @(posedge CLK);
    if (rst || flush) begin
      q_d.delete();
      q_v.delete();
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_d.push_back('0);
        q_v.push_back(1'b0);
      end
      m_fill = 0;
    end else if (ce) begin
      q_d.push_front(d);
      q_v.push_front(dv);
      void'(q_d.pop_back());
      void'(q_v.pop_back());
      if (dv && m_fill < int'(DEPTH)) m_fill++;
    end
  endtask

  // Just after an edge: switch the tap and check against fixed expectations.
  task automatic probe(input string tag, input int tap,
                       input logic [31:0] e_out, input bit e_vld, input int e_fill);
    bus.TAP = TW'(tap);
    #1;
    chk({tag, "_out"},  32'(bus.OUT),     e_out);
    chk({tag, "_vld"},  32'(bus.OUT_VLD), 32'(e_vld));
    chk({tag, "_fill"}, 32'(bus.FILL),    32'(e_fill));
  endtask

  initial begin
    RST = 1'b1; bus.FLUSH = 1'b0; bus.CE = 1'b1;
    bus.D = '0; bus.D_VLD = 1'b0; bus.TAP = '0;

    // Reset with a full-scale input held on D.
    step(1, 0, 1, 18'h3FFFF, 1, 1);
    step(1, 0, 1, 18'h3FFFF, 1, 1);
    chk_en = 1'b1;
    for (int t = 1; t <= int'(DEPTH); t++) probe("rst_tap", t, 32'h0, 1'b0, 0);
    step(0, 0, 0, 18'h3FFFF, 1, 0);
    probe("rst_bypass", 0, 32'h3FFFF, 1'b1, 0);

    // Latency sweep at tap 3.
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 1, SIZE'(i), 1, 3);
      probe("lat", 3, (i >= 3) ? 32'(i - 2) : 32'h0, (i >= 3), (i < 4) ? i : 4);
    end

    // Stall with a bubble in flight at tap 2.
    step(1, 0, 1, '0, 0, 2);
    step(0, 0, 1, 18'h10, 1, 2);
    step(0, 0, 1, 18'h99, 0, 2);
    probe("stall_a", 2, 32'h10, 1'b1, 1);
    step(0, 0, 1, 18'h20, 1, 2);
    probe("stall_b", 2, 32'h99, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 18'h3ABCD, 1, 2);
      probe("stall_hold", 2, 32'h99, 1'b0, 2);
    end
    step(0, 0, 1, 18'h0, 0, 2);
    probe("stall_c", 2, 32'h20, 1'b1, 2);

    // Flush wins over a simultaneous valid capture.
    for (int i = 1; i <= 4; i++) step(0, 0, 1, SIZE'(i), 1, 1);
    probe("full", 4, 32'h1, 1'b1, 4);
    step(0, 1, 1, 18'h55, 1, 1);
    probe("flush_t1", 1, 32'h0, 1'b0, 0);
    probe("flush_t4", 4, 32'h0, 1'b0, 0);
    step(0, 0, 1, 18'h55, 1, 1);
    probe("post_flush", 1, 32'h55, 1'b1, 1);

    // Tap switching and clamping while stalled.
    step(0, 0, 1, 18'hD, 1, 0);
    step(0, 0, 1, 18'hC, 1, 0);
    step(0, 0, 1, 18'hB, 1, 0);
    step(0, 0, 1, 18'hA, 1, 0);
    step(0, 0, 0, 18'h77, 1, 1);
    probe("tap1", 1, 32'hA,  1'b1, 4);
    probe("tap4", 4, 32'hD,  1'b1, 4);
    probe("tap0", 0, 32'h77, 1'b1, 4);
    probe("tap7", 7, 32'hD,  1'b1, 4);
    step(0, 0, 0, 18'h77, 1, 4);
    probe("tap1_again", 1, 32'hA, 1'b1, 4);

    // Reset and flush together, then flush alone keeps the chain clear.
    step(1, 1, 1, 18'h11, 1, 1);
    probe("prio_rst", 1, 32'h0, 1'b0, 0);
    step(0, 1, 1, 18'h22, 1, 1);
    probe("prio_fl1", 1, 32'h0, 1'b0, 0);
    step(0, 1, 1, 18'h22, 1, 1);
    probe("prio_fl2", 1, 32'h0, 1'b0, 0);
    step(0, 0, 1, 18'h33, 1, 1);
    probe("prio_rel", 1, 32'h33, 1'b1, 1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 75,
           SIZE'($urandom),
           $urandom_range(0, 99) < 70,
           int'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
